axi_ram_initiator: RTL and testbench

AXI_RAM_INITIATOR -- requirements
Module: axi_ram_initiator

---
 rtl/axi_ram_initiator.sv | 129 ++++++++++++
 tb/tb_axi_ram_initiator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : axi_ram_initiator
//  Description : Single-outstanding RAM initiator with handshake timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_ram_initiator #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  AXI_RAM_INIT_Clk,
    input  logic                  AXI_RAM_INIT_Reset_InLow,
    input  logic                  AXI_RAM_INIT_Req_Valid,
    input  logic                  AXI_RAM_INIT_Req_Write,
    input  logic [ADDR_WIDTH-1:0] AXI_RAM_INIT_Req_Addr,
    input  logic [31:0]           AXI_RAM_INIT_Req_Wdata,
    output logic                  AXI_RAM_INIT_Req_Ready,
    output logic                  AXI_RAM_INIT_Resp_Valid,
    output logic                  AXI_RAM_INIT_Resp_Err,
    output logic [31:0]           AXI_RAM_INIT_Resp_Rdata,
    output logic                  AXI_RAM_INIT_Read_Ready,
    output logic                  AXI_RAM_INIT_Write_Valid,
    output logic [ADDR_WIDTH-1:0] AXI_RAM_INIT_Address,
    output logic [31:0]           AXI_RAM_INIT_Data_Out,
    input  logic                  AXI_RAM_INIT_Read_Valid,
    input  logic                  AXI_RAM_INIT_Write_Ready,
    input  logic [31:0]           AXI_RAM_INIT_Data_In
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic [7:0]            r_wait_cnt;
    logic                  r_err_flag;
    logic                  r_resp_valid;
    logic                  r_read_ready;
    logic                  r_write_valid;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [31:0]           r_data_out;
    logic [31:0]           r_resp_rdata;
    logic                  w_wait_expired;

    assign w_wait_expired = (r_wait_cnt == c_WAIT_LAST);

    // Strobes and response are registered alongside the state so every output
    // changes on the same edge as the state it belongs to.
    always_ff @(posedge AXI_RAM_INIT_Clk or negedge AXI_RAM_INIT_Reset_InLow) begin
        if (!AXI_RAM_INIT_Reset_InLow) begin
            r_state       <= IDLE;
            r_wait_cnt    <= 8'd0;
            r_err_flag    <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_read_ready  <= 1'b0;
            r_write_valid <= 1'b0;
            r_address     <= '0;
            r_data_out    <= 32'd0;
            r_resp_rdata  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_resp_valid <= 1'b0;
                    r_err_flag   <= 1'b0;
                    if (AXI_RAM_INIT_Req_Valid) begin
                        r_address     <= AXI_RAM_INIT_Req_Addr;
                        r_data_out    <= AXI_RAM_INIT_Req_Wdata;
                        r_wait_cnt    <= 8'd0;
                        r_write_valid <= AXI_RAM_INIT_Req_Write;
                        r_read_ready  <= ~AXI_RAM_INIT_Req_Write;
                        r_state       <= AXI_RAM_INIT_Req_Write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    // Handshake wins over a timeout landing on the same edge.
                    if (AXI_RAM_INIT_Write_Ready || w_wait_expired) begin
                        r_write_valid <= 1'b0;
                        r_resp_valid  <= 1'b1;
                        r_err_flag    <= ~AXI_RAM_INIT_Write_Ready;
                        r_state       <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                READ: begin
                    if (AXI_RAM_INIT_Read_Valid) begin
                        r_resp_rdata <= AXI_RAM_INIT_Data_In;
                    end
                    if (AXI_RAM_INIT_Read_Valid || w_wait_expired) begin
                        r_read_ready <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_err_flag   <= ~AXI_RAM_INIT_Read_Valid;
                        r_state      <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_err_flag   <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state       <= IDLE;
                    r_resp_valid  <= 1'b0;
                    r_read_ready  <= 1'b0;
                    r_write_valid <= 1'b0;
                end
            endcase
        end
    end

    // Gated by reset so ready is low while held in reset and high right after.
    assign AXI_RAM_INIT_Req_Ready   = (r_state == IDLE) & AXI_RAM_INIT_Reset_InLow;
    assign AXI_RAM_INIT_Resp_Valid  = r_resp_valid;
    assign AXI_RAM_INIT_Resp_Err    = r_err_flag & r_resp_valid;
    assign AXI_RAM_INIT_Resp_Rdata  = r_resp_rdata;
    assign AXI_RAM_INIT_Read_Ready  = r_read_ready;
    assign AXI_RAM_INIT_Write_Valid = r_write_valid;
    assign AXI_RAM_INIT_Address     = r_address;
    assign AXI_RAM_INIT_Data_Out    = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_ram_initiator
//  Description : Directed and random transfers against a RAM/response model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_ram_initiator;

    localparam int c_AW      = 10;
    localparam int c_TIMEOUT = 16;

    logic              tb_clk_50 = 1'b0;
    logic              rst_n;
    logic              req_valid, req_write;
    logic [c_AW-1:0]   req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready, resp_valid, resp_err;
    logic [31:0]       resp_rdata;
    logic              read_ready, write_valid;
    logic [c_AW-1:0]   address;
    logic [31:0]       data_out;
    logic              read_valid, write_ready;
    logic [31:0]       data_in;

    int                n_checks = 0;
    int                n_fails  = 0;
    logic [31:0]       mem [0:(1<<c_AW)-1];
    logic [31:0]       model_rdata;

    always #10 tb_clk_50 = ~tb_clk_50;

    axi_ram_initiator #(.ADDR_WIDTH(c_AW), .TIMEOUT_CYCLES(c_TIMEOUT)) dut (
        .AXI_RAM_INIT_Clk         (tb_clk_50),
        .AXI_RAM_INIT_Reset_InLow (rst_n),
        .AXI_RAM_INIT_Req_Valid   (req_valid),
        .AXI_RAM_INIT_Req_Write   (req_write),
        .AXI_RAM_INIT_Req_Addr    (req_addr),
        .AXI_RAM_INIT_Req_Wdata   (req_wdata),
        .AXI_RAM_INIT_Req_Ready   (req_ready),
        .AXI_RAM_INIT_Resp_Valid  (resp_valid),
        .AXI_RAM_INIT_Resp_Err    (resp_err),
        .AXI_RAM_INIT_Resp_Rdata  (resp_rdata),
        .AXI_RAM_INIT_Read_Ready  (read_ready),
        .AXI_RAM_INIT_Write_Valid (write_valid),
        .AXI_RAM_INIT_Address     (address),
        .AXI_RAM_INIT_Data_Out    (data_out),
        .AXI_RAM_INIT_Read_Valid  (read_valid),
        .AXI_RAM_INIT_Write_Ready (write_ready),
        .AXI_RAM_INIT_Data_In     (data_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},   32'(req_ready),   32'd0);
        check({tag, "_resp_valid"},  32'(resp_valid),  32'd0);
        check({tag, "_resp_err"},    32'(resp_err),    32'd0);
        check({tag, "_read_ready"},  32'(read_ready),  32'd0);
        check({tag, "_write_valid"}, 32'(write_valid), 32'd0);
        check({tag, "_address"},     32'(address),     32'd0);
        check({tag, "_data_out"},    data_out,         32'd0);
        check({tag, "_resp_rdata"},  resp_rdata,       32'd0);
    endtask

    // One transfer starting just after a falling edge in IDLE. hs is the wait
    // cycle (1-based) on which the RAM answers; 0 or > timeout means never.
    // The request stays asserted with the same fields for the whole transfer.
    task automatic do_txn(input bit wr, input logic [c_AW-1:0] a,
                          input logic [31:0] d, input int hs);
        int  cyc;
        bit  done;
        bit  exp_err;
        check("ready_in_idle", 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_write   = wr;
        req_addr    = a;
        req_wdata   = d;
        read_valid  = 1'($urandom);
        write_ready = 1'($urandom);
        data_in     = $urandom;
        @(posedge tb_clk_50);
        @(negedge tb_clk_50);
        exp_err = (hs < 1) || (hs > c_TIMEOUT);
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            cyc++;
            check("write_valid", 32'(write_valid), 32'(wr));
            check("read_ready",  32'(read_ready),  32'(!wr));
            check("busy_ready",  32'(req_ready),   32'd0);
            check("busy_resp",   32'(resp_valid),  32'd0);
            check("address",     32'(address),     32'(a));
            if (wr) check("data_out", data_out, d);
            data_in = $urandom;
            if (wr) begin
                write_ready = (cyc == hs);
                read_valid  = 1'($urandom);
            end else begin
                read_valid  = (cyc == hs);
                write_ready = 1'($urandom);
                if (cyc == hs) data_in = mem[a];
            end
            @(posedge tb_clk_50);
            @(negedge tb_clk_50);
            if (cyc == hs || cyc >= c_TIMEOUT) done = 1'b1;
        end
        if (wr && !exp_err) mem[a] = d;
        if (!wr && !exp_err) model_rdata = mem[a];
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_err",   32'(resp_err),   32'(exp_err));
        check("resp_rdata", resp_rdata,      model_rdata);
        check("resp_strobes", 32'({write_valid, read_ready, req_ready}), 32'd0);
        read_valid  = 1'($urandom);
        write_ready = 1'($urandom);
        data_in     = $urandom;
        @(posedge tb_clk_50);
        @(negedge tb_clk_50);
        check("resp_pulse_end", 32'(resp_valid), 32'd0);
        check("back_to_idle",   32'(req_ready),  32'd1);
        check("rdata_hold",     resp_rdata,      model_rdata);
    endtask

    task automatic go_idle(input int n);
        req_valid   = 1'b0;
        read_valid  = 1'b0;
        write_ready = 1'b0;
        repeat (n) @(negedge tb_clk_50);
    endtask

    initial begin
        for (int i = 0; i < (1 << c_AW); i++) mem[i] = $urandom;
        model_rdata = 32'd0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = 32'd0;
        read_valid  = 1'b1;
        write_ready = 1'b1;
        data_in     = 32'hFFFF_FFFF;

        // Reset state
        #5;
        check_all_zero("reset");
        @(negedge tb_clk_50);
        @(negedge tb_clk_50);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);
        go_idle(1);

        // Basic write, write-then-read, timeouts and the last-cycle handshake
        do_txn(1'b1, 10'h000, 32'h0000_0010, 1);
        do_txn(1'b1, 10'h155, 32'hDEAD_BEEF, 1);
        do_txn(1'b0, 10'h155, 32'h0, 3);
        check("read_back_deadbeef", resp_rdata, 32'hDEAD_BEEF);
        go_idle(2);
        do_txn(1'b0, 10'h2A0, 32'h0, 0);
        do_txn(1'b1, 10'h3FF, 32'h1234_5678, 16);
        do_txn(1'b1, 10'h3FE, 32'hCAFE_F00D, 17);
        do_txn(1'b0, 10'h3FF, 32'h0, 16);
        go_idle(1);

        // Reset pulsed in the middle of a read
        check("ready_pre_abort", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 10'h0F0;
        read_valid = 1'b0;
        @(posedge tb_clk_50);
        @(negedge tb_clk_50);
        req_valid = 1'b0;
        check("abort_read_ready", 32'(read_ready), 32'd1);
        repeat (4) @(negedge tb_clk_50);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        read_valid = 1'b1;
        @(negedge tb_clk_50);
        check("abort_no_resp", 32'(resp_valid), 32'd0);
        rst_n = 1'b1;
        read_valid = 1'b0;
        model_rdata = 32'd0;
        #1;
        check("abort_ready", 32'(req_ready), 32'd1);
        do_txn(1'b0, 10'h155, 32'h0, 2);

        // Back-to-back requests with the request held high throughout
        for (int i = 0; i < 4; i++)
            do_txn(i[0], 10'(i + 3), $urandom, 1);

        // Random traffic over a small address window so reads hit prior writes
        for (int i = 0; i < 24; i++)
            do_txn(1'($urandom), 10'($urandom_range(0, 7)), $urandom,
                   int'($urandom_range(0, 19)));
        go_idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
